// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: raster-scan sequencer in front of row_buffer.
// Tags each accepted sample with column/row indices and boundary flags,
// pulses 'move' once per completed row and 'done' once per finished frame.
module row_scan_ctrl #(
    parameter int WIDTH = 32,
    parameter int COL_W = 16,
    parameter int ROW_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [COL_W-1:0] cfg_cols,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] out_col,
    output logic [ROW_W-1:0] out_row,
    output logic             out_first_row,
    output logic             out_first_col,
    output logic             out_last,
    output logic             move,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] cols_q, cols_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic             out_first_row_q, out_first_row_d;
    logic             out_first_col_q, out_first_col_d;
    logic             out_last_q, out_last_d;
    logic             move_q, move_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic accept;
    logic col_wrap;
    logic row_end;

    // Input handshake: take a new sample only when the output register is free or draining.
    always_comb begin
        in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        col_wrap = (col_q == cols_q - COL_W'(1));
        row_end  = (row_q == rows_q - ROW_W'(1));
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d         = state_q;
        cols_d          = cols_q;
        rows_d          = rows_q;
        col_d           = col_q;
        row_d           = row_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        out_col_d       = out_col_q;
        out_row_d       = out_row_q;
        out_first_row_d = out_first_row_q;
        out_first_col_d = out_first_col_q;
        out_last_d      = out_last_q;
        move_d          = 1'b0;
        done_d          = 1'b0;
        cfg_err_d       = 1'b0;

        // Output register drains on out_ready unless refilled by a new accept below.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_cols == '0 || cfg_rows == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cols_d  = cfg_cols;
                        rows_d  = cfg_rows;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    out_data_d      = in_data;
                    out_valid_d     = 1'b1;
                    out_col_d       = col_q;
                    out_row_d       = row_q;
                    out_first_row_d = (row_q == '0);
                    out_first_col_d = (col_q == '0);
                    out_last_d      = col_wrap && row_end;
                    if (col_wrap) begin
                        col_d  = '0;
                        row_d  = row_q + ROW_W'(1);
                        move_d = 1'b1;
                        if (row_end) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE: begin
                // Frame is only complete once the final beat has left the output register.
                if (out_valid_q && out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cols_q          <= '0;
            rows_q          <= '0;
            col_q           <= '0;
            row_q           <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_col_q       <= '0;
            out_row_q       <= '0;
            out_first_row_q <= 1'b0;
            out_first_col_q <= 1'b0;
            out_last_q      <= 1'b0;
            move_q          <= 1'b0;
            done_q          <= 1'b0;
            cfg_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cols_q          <= cols_d;
            rows_q          <= rows_d;
            col_q           <= col_d;
            row_q           <= row_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_col_q       <= out_col_d;
            out_row_q       <= out_row_d;
            out_first_row_q <= out_first_row_d;
            out_first_col_q <= out_first_col_d;
            out_last_q      <= out_last_d;
            move_q          <= move_d;
            done_q          <= done_d;
            cfg_err_q       <= cfg_err_d;
        end
    end

    // Output wiring.
    always_comb begin
        out_data      = out_data_q;
        out_valid     = out_valid_q;
        out_col       = out_col_q;
        out_row       = out_row_q;
        out_first_row = out_first_row_q;
        out_first_col = out_first_col_q;
        out_last      = out_last_q;
        move          = move_q;
        busy          = (state_q == RUN);
        done          = done_q;
        cfg_err       = cfg_err_q;
    end

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Directed testbench for row_scan_ctrl.
module tb_row_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_cols;
    logic [15:0] cfg_rows;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_col;
    logic [15:0] out_row;
    logic        out_first_row;
    logic        out_first_col;
    logic        out_last;
    logic        move;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    row_scan_ctrl #(.WIDTH(32), .COL_W(16), .ROW_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_cols     (cfg_cols),
        .cfg_rows     (cfg_rows),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_col      (out_col),
        .out_row      (out_row),
        .out_first_row(out_first_row),
        .out_first_col(out_first_col),
        .out_last     (out_last),
        .move         (move),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the accepting posedge.
    task automatic do_start(input int c, input int r);
        @(negedge clk);
        start     = 1'b1;
        cfg_cols  = 16'(c);
        cfg_rows  = 16'(r);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a frame and stream it through, checking every beat against the raster model.
    task automatic run_frame(input int c, input int r, input logic [31:0] base,
                             input bit rv, input bit rr, input int inj);
        int  tot;
        int  acc;
        int  cons;
        int  moves;
        int  cyc;
        bit  acc_prev;
        bit  acc_prev_wrap;
        tot = c * r;
        acc = 0; cons = 0; moves = 0; cyc = 0;
        acc_prev = 1'b0; acc_prev_wrap = 1'b0;
        do_start(c, r);
        chk("busy_after_start", busy, 1);
        while (cons < tot && cyc < 4000) begin
            chk("move", move, acc_prev && acc_prev_wrap);
            if (move) moves++;
            chk("done_in_frame", done, 0);
            chk("cfg_err_in_frame", cfg_err, 0);
            if (out_valid) begin
                chk("out_col", out_col, cons % c);
                chk("out_row", out_row, cons / c);
                chk("out_data", out_data, base + cons);
                chk("out_first_row", out_first_row, (cons / c) == 0);
                chk("out_first_col", out_first_col, (cons % c) == 0);
                chk("out_last", out_last, cons == tot - 1);
            end
            in_valid  = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = in_valid ? base + acc : $urandom;
            start     = (cyc == inj);
            if (cyc == inj) begin
                cfg_cols = 16'd2;
                cfg_rows = 16'd2;
            end
            #1;
            acc_prev      = in_valid && in_ready;
            acc_prev_wrap = ((acc % c) == c - 1);
            if (out_valid && out_ready) cons++;
            if (acc_prev) acc++;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("frame_timeout", cyc < 4000, 1);
        chk("accepted_count", acc, tot);
        chk("move_count", moves, r);
        chk("move_after_last", move, 0);
        chk("done_pulse", done, 1);
        chk("busy_after_frame", busy, 0);
        chk("out_valid_after_frame", out_valid, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("in_ready_idle", in_ready, 0);
        $display("frame cols=%0d rows=%0d beats=%0d moves=%0d cycles=%0d", c, r, cons, moves, cyc);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        cfg_cols  = '0;
        cfg_rows  = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_done", done, 0);
        rst = 1'b1;

        // 1: 4x3 frame, no stalls.
        run_frame(4, 3, 32'h1000, 1'b0, 1'b0, -1);

        // 2: 49x2 frame, random stalls on both sides.
        run_frame(49, 2, 32'h2000, 1'b1, 1'b1, -1);

        // 3: start with cfg_cols == 0 is rejected.
        do_start(0, 3);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        in_valid = 1'b1;
        #1;
        chk("cfg_err_in_ready", in_ready, 0);
        @(negedge clk);
        chk("cfg_err_one_cycle", cfg_err, 0);
        chk("cfg_err_still_idle", busy, 0);
        in_valid = 1'b0;
        $display("rejected start cols=0 rows=3");

        // 4: asynchronous reset in the middle of the second row of a 4x3 frame.
        do_start(4, 3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'h3000 + i;
            @(negedge clk);
        end
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_col", out_col, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_col", out_col, 0);
        chk("async_out_row", out_row, 0);
        chk("async_out_data", out_data, 0);
        chk("async_busy", busy, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_move", move, 0);
        @(negedge clk);
        chk("reset_no_done", done, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        $display("async reset mid-frame");
        run_frame(4, 3, 32'h4000, 1'b0, 1'b0, -1);

        // 5: single-column frame.
        run_frame(1, 3, 32'h5000, 1'b0, 1'b0, -1);

        // 6: start pulsed mid-frame with a different cfg is ignored.
        run_frame(4, 3, 32'h6000, 1'b0, 1'b1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
